// File: rtl/neuron.sv
// Two-input signed multiply-accumulate cell: result = i1*w1 + i2*w2.
// Two register stages (products, then sum); one operand set per clock.
module neuron #(
  parameter int unsigned DATA_W = 8,
  localparam int unsigned RES_W = 2 * DATA_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i1,
  input  logic [DATA_W-1:0] i2,
  input  logic [DATA_W-1:0] w1,
  input  logic [DATA_W-1:0] w2,
  output logic [RES_W-1:0]  result
);

  localparam int unsigned ProdW = 2 * DATA_W;

  logic signed [ProdW-1:0] i1_ext, i2_ext, w1_ext, w2_ext;
  logic signed [ProdW-1:0] p1_d, p2_d;
  logic signed [ProdW-1:0] p1_q, p2_q;
  logic signed [RES_W-1:0] sum_d;
  logic signed [RES_W-1:0] result_q;

  // Widen operands to the product width first so the multiply is done at
  // full precision; the low ProdW bits of the product are then exact.
  always_comb begin
    i1_ext = {{DATA_W{i1[DATA_W-1]}}, i1};
    i2_ext = {{DATA_W{i2[DATA_W-1]}}, i2};
    w1_ext = {{DATA_W{w1[DATA_W-1]}}, w1};
    w2_ext = {{DATA_W{w2[DATA_W-1]}}, w2};
    p1_d   = i1_ext * w1_ext;
    p2_d   = i2_ext * w2_ext;
  end

  // One guard bit makes the sum of two products impossible to overflow.
  always_comb begin
    sum_d = {p1_q[ProdW-1], p1_q} + {p2_q[ProdW-1], p2_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_q     <= '0;
      p2_q     <= '0;
      result_q <= '0;
    end else begin
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      result_q <= sum_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_neuron.sv
// Randomized and directed checks of the neuron against an arithmetic model
// that predicts each edge's result from the operands and reset one edge earlier.
module tb_neuron;

  logic        clk;
  logic        reset;
  logic [7:0]  i1, i2, w1, w2;
  logic [16:0] result;

  int total = 0;
  int bad   = 0;

  // Model state: what the cell saw on the previous edge.
  bit prev_rst = 1'b1;
  int prev_sum = 0;

  neuron #(.DATA_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .i1     (i1),
    .i2     (i2),
    .w1     (w1),
    .w2     (w2),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%05h) want %0d (0x%05h) at %0t",
               tag, $signed(got), got, $signed(exp), exp, $time);
    end
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  // Apply one operand set for one edge and check the result after that edge.
  task automatic step(input string tag, input int a1, input int a2, input int b1,
                      input int b2, input bit r);
    int          exp_i;
    logic [16:0] exp_v;
    @(negedge clk);
    i1    = a1[7:0];
    i2    = a2[7:0];
    w1    = b1[7:0];
    w2    = b2[7:0];
    reset = r;
    @(posedge clk);
    #1;
    // Reset zeroes the products on its edge and the result on the same edge,
    // so a reset on either of the last two edges yields zero.
    exp_i = (r || prev_rst) ? 0 : prev_sum;
    exp_v = exp_i[16:0];
    check(tag, result, exp_v);
    prev_rst = r;
    prev_sum = a1 * b1 + a2 * b2;
  endtask

  typedef struct {
    string name;
    int    a1, a2, b1, b2;
    int    want;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          w;
    logic [16:0] want_v;

    vecs[0] = '{"pos",      5,    3,    2,    4,  22};
    vecs[1] = '{"neg_in",  -2,   -3,    3,    2, -12};
    vecs[2] = '{"neg_w",    4,    6,   -2,   -3, -26};
    vecs[3] = '{"all_neg", -3,   -2,   -4,   -5,  22};
    vecs[4] = '{"ext_max", -128, -128, -128, -128, 32768};
    vecs[5] = '{"ext_min", -128, -128, 127,  127, -32512};

    reset = 1'b1;
    i1 = '0; i2 = '0; w1 = '0; w2 = '0;

    for (int k = 0; k < 10; k++) step("rst_hold", rnd8(), rnd8(), rnd8(), rnd8(), 1'b1);
    for (int k = 0; k < 4; k++) step("rst_rel0", 0, 0, 0, 0, 1'b0);

    // Each directed vector held for three edges: result valid on the second, then stable.
    foreach (vecs[v]) begin
      for (int k = 0; k < 3; k++) begin
        step(vecs[v].name, vecs[v].a1, vecs[v].a2, vecs[v].b1, vecs[v].b2, 1'b0);
        if (k >= 1) begin
          w      = vecs[v].want;
          want_v = w[16:0];
          check({vecs[v].name, "_lit"}, result, want_v);
        end
      end
    end

    // Back-to-back random operand sets, including the extremes.
    for (int k = 0; k < 300; k++) begin
      if (k % 50 == 7) step("b2b_ext", -128, -128, -128, -128, 1'b0);
      else             step("b2b", rnd8(), rnd8(), rnd8(), rnd8(), 1'b0);
    end

    // Single-cycle reset pulses while the pipeline is full.
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 5; k++) step("pre_rst", rnd8(), rnd8(), rnd8(), rnd8(), 1'b0);
      step("mid_rst", rnd8(), rnd8(), rnd8(), rnd8(), 1'b1);
      for (int k = 0; k < 4; k++) step("post_rst", rnd8(), rnd8(), rnd8(), rnd8(), 1'b0);
    end

    // Random reset density with random data.
    for (int k = 0; k < 300; k++)
      step("mix", rnd8(), rnd8(), rnd8(), rnd8(), ($urandom_range(0, 9) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron.md
Name: neuron

Overview:
- Two-input signed multiply-accumulate neuron: result = i1*w1 + i2*w2.
- Pipelined, fully synchronous, one result per clock, no activation function.
- Used as the basic dot-product cell in the fixed-point convnet hardware path. Upstream provides inputs and weights; downstream consumes the raw weighted sum.

Parameters:
- DATA_W, 8, width of each signed input and weight (two's complement).
- RES_W, 2*DATA_W+1 (17), result width; derived, not to be overridden independently.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- i1  input  DATA_W  signed input 1, two's complement.
- i2  input  DATA_W  signed input 2.
- w1  input  DATA_W  signed weight for i1.
- w2  input  DATA_W  signed weight for i2.
- result  output  RES_W  signed weighted sum, registered.

Behaviour:
- Single clock domain. All state updates on the rising edge of clk. No asynchronous logic.
- All operands are treated as signed two's complement. Each product is sign-extended before addition.
- Stage 1, registered:
  - p1 <= i1*w1, 2*DATA_W bits signed.
  - p2 <= i2*w2, 2*DATA_W bits signed.
- Stage 2, registered:
  - result <= sext(p1) + sext(p2), RES_W bits signed.
- Latency is exactly 2 clock edges from input sample to result update. Throughput is one new operand set per cycle. No handshake and no valid signal.
- result is held until overwritten by the pipeline. It is a pure register output with no combinational path from inputs.
- Reset, synchronous active-high:
  - On any rising edge with reset=1, p1, p2 and result all load 0.
  - result reads 0 from the first edge after reset is sampled high and stays 0 while reset is held.
- Reset mid-operation: in-flight products are discarded.
  - The first edge with reset=0 captures current inputs into stage 1.
  - result shows that value on the second edge after reset is released.
- Width and overflow:
  - RES_W = 17 covers the full range, so the sum never overflows and no saturation logic is needed.
  - Extremes: (-128)*(-128)*2 = 32768; (-128)*127*2 = -32512.
- Inputs changing every cycle produce a result stream delayed by 2 cycles with no gaps or duplicates.
- Inputs are unconstrained. X or Z on inputs is not defined behaviour; the bench drives known values only.

Test Plan:
- Reset: hold reset=1 for 10 cycles with random inputs -> result=0 throughout. Release reset with all inputs 0 -> result stays 0.
- Positive values: i1=5, i2=3, w1=2, w2=4 -> result=22, 2 cycles after inputs are applied, then held stable.
- Negative inputs: i1=-2, i2=-3, w1=3, w2=2 -> result=-12 (0x1FFF4). Negative weights: i1=4, i2=6, w1=-2, w2=-3 -> result=-26.
- All negative: i1=-3, i2=-2, w1=-4, w2=-5 -> result=22.
- Extremes:
  - i1=i2=w1=w2=-128 -> result=32768.
  - i1=i2=-128, w1=w2=127 -> result=-32512.
  - Back-to-back operand sets on consecutive cycles -> each result appears exactly 2 cycles later, in order.
- Reset mid-stream: assert reset for 1 cycle while the pipeline is full -> result=0 on the next edge. The first post-reset input set appears 2 edges after release.
